// File: rtl/enc_pkg.sv
// Shared constants and helpers for the round-robin priority encoder.
// Holds the mode selectors and a width helper that never returns zero.
package enc_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // A 2-line encoder still needs a 1-bit index, so never return zero.
    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_find_first.sv
// Combinational find-first-set: reports the lowest set bit of vec.
// When nothing is set, idx is 0 and found is 0.
module prio_find_first
    import enc_pkg::*;
#(
    parameter int N = 8,
    localparam int W = safe_clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         found
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_priority_encoder.sv
// N-to-log2(N) priority encoder with a registered result and valid/ready on both sides.
// MODE selects fixed or round-robin priority; define RR_ENC_MULTI_HOT_EN to add the multi output.
module rr_priority_encoder
    import enc_pkg::*;
#(
    parameter int N = 8,
    localparam int W = safe_clog2(N),
    parameter int MODE = MODE_FIXED
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] idx,
`ifdef RR_ENC_MULTI_HOT_EN
    output logic         multi,
`endif
    output logic         none
);

    logic         accept;
    logic [W-1:0] grant_idx;
    logic         grant_found;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    if (MODE == MODE_RR) begin : g_rr
        logic [W-1:0] ptr;
        logic [N-1:0] mask;
        logic [N-1:0] masked;
        logic [W-1:0] masked_idx;
        logic [W-1:0] full_idx;
        logic         masked_found;
        logic         full_found;

        // Keep only bits at or above ptr; the unmasked search handles the wrap.
        always_comb begin
            mask = '0;
            for (int i = 0; i < N; i++) begin
                mask[i] = (i >= int'(ptr));
            end
        end

        assign masked = req & mask;

        prio_find_first #(.N(N)) u_masked (
            .vec   (masked),
            .idx   (masked_idx),
            .found (masked_found)
        );

        prio_find_first #(.N(N)) u_full (
            .vec   (req),
            .idx   (full_idx),
            .found (full_found)
        );

        assign grant_idx   = masked_found ? masked_idx : full_idx;
        assign grant_found = full_found;

        // The increment wraps N-1 back to 0 through W-bit overflow.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ptr <= '0;
            end else if (accept && grant_found) begin
                ptr <= grant_idx + W'(1);
            end
        end
    end else begin : g_fixed
        prio_find_first #(.N(N)) u_find (
            .vec   (req),
            .idx   (grant_idx),
            .found (grant_found)
        );
    end

`ifdef RR_ENC_MULTI_HOT_EN
    logic multi_hot;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_hot = |(req & (req - N'(1)));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            idx       <= '0;
            none      <= 1'b0;
`ifdef RR_ENC_MULTI_HOT_EN
            multi     <= 1'b0;
`endif
        end else if (accept) begin
            out_valid <= 1'b1;
            idx       <= grant_found ? grant_idx : '0;
            none      <= !grant_found;
`ifdef RR_ENC_MULTI_HOT_EN
            multi     <= multi_hot;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
